// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_EQZ = 1;
    localparam int unsigned OP_LTZ = 2;
    localparam int unsigned OP_ADD = 3;
    localparam int unsigned OP_SUB = 4;
    localparam int unsigned OP_MUL = 5;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    typedef enum logic {
        StIdle,
        StMulBusy
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles per start.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The final step's sum is presented directly so the result lands on the same edge.
    assign product  = acc_step;

    always_comb begin
        busy_d   = busy_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        if (start) begin
            busy_d   = 1'b1;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                done   = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result slot; single-cycle ops plus an iterative MUL.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   inst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             statupd8,
    output logic [3:0]       flags
);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             stat_q, stat_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept, is_mul, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [WIDTH-1:0] res_o;
    logic             res_s;
    logic [3:0]       res_f;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (inst == OPW'(OP_MUL));
    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign statupd8  = stat_q;
    assign flags     = flags_q;

    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} - {1'b0, b};

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (CLK),
        .rst_n   (RST),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        res_o = '0;
        res_s = 1'b0;
        res_f = '0;
        case (inst)
            OPW'(OP_EQZ), OPW'(OP_LTZ): begin
                res_s        = (inst == OPW'(OP_EQZ)) ? (a == '0) : a[WIDTH-1];
                res_f[FLG_N] = a[WIDTH-1];
                res_f[FLG_Z] = (a == '0);
            end
            OPW'(OP_ADD): begin
                res_o        = add_ext[WIDTH-1:0];
                res_f[FLG_C] = add_ext[WIDTH];
                res_f[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
                res_f[FLG_N] = add_ext[WIDTH-1];
                res_f[FLG_Z] = (add_ext[WIDTH-1:0] == '0);
            end
            OPW'(OP_SUB): begin
                res_o        = sub_ext[WIDTH-1:0];
                res_f[FLG_C] = sub_ext[WIDTH];
                res_f[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
                res_f[FLG_N] = sub_ext[WIDTH-1];
                res_f[FLG_Z] = (sub_ext[WIDTH-1:0] == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        o_d         = o_q;
        stat_d      = stat_q;
        flags_d     = flags_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = StMulBusy;
                    end else begin
                        out_valid_d = 1'b1;
                        o_d         = res_o;
                        stat_d      = res_s;
                        flags_d     = res_f;
                    end
                end
            end
            StMulBusy: begin
                if (mul_done) begin
                    state_d        = StIdle;
                    out_valid_d    = 1'b1;
                    o_d            = mul_product;
                    stat_d         = 1'b0;
                    flags_d        = '0;
                    flags_d[FLG_N] = mul_product[WIDTH-1];
                    flags_d[FLG_Z] = (mul_product == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            o_q         <= '0;
            stat_q      <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
            stat_q      <= stat_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   inst = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] o;
    logic         statupd8;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    alu_seq #(
        .WIDTH (W),
        .OPW   (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .statupd8  (statupd8),
        .flags     (flags)
    );

    always #5 CLK = ~CLK;

    // Reference: results straight from integer arithmetic on the operand values.
    function automatic void model(input logic [7:0] op, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] ro, output logic rs, output logic [3:0] rf);
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        ro = '0;
        rs = 1'b0;
        rf = '0;
        case (op)
            8'd1, 8'd2: begin
                rs = (op == 8'd1) ? (ux == 0) : (sx < 0);
                rf = {sx < 0, ux == 0, 2'b00};
            end
            8'd3: begin
                r  = ux + uy;
                sr = sx + sy;
                ro = r[7:0];
                rf = {ro[7], ro == 8'd0, r > 255, (sr > 127) || (sr < -128)};
            end
            8'd4: begin
                r  = ux - uy;
                sr = sx - sy;
                ro = r[7:0];
                rf = {ro[7], ro == 8'd0, ux < uy, (sr > 127) || (sr < -128)};
            end
            8'd5: begin
                r  = (ux * uy) % 256;
                ro = r[7:0];
                rf = {ro[7], ro == 8'd0, 2'b00};
            end
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] rand_op(input bit allow_mul);
        int r;
        r = $urandom_range(0, 7);
        if (r == 5 && !allow_mul) r = 3;
        if (r < 6) return 8'(r);
        return 8'($urandom_range(6, 255));
    endfunction

    task automatic test_reset();
        RST = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (o !== 8'h00) begin errors++; $display("FAIL reset_o got %h want 00", o); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %h want 0", flags); end
        checks++; if (statupd8 !== 1'b0) begin errors++; $display("FAIL reset_stat got %b want 0", statupd8); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_add_sub();
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 8'd3; a = 8'h7F; b = 8'h01;
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", out_valid); end
        checks++; if (o !== 8'h80) begin errors++; $display("FAIL add_o got %h want 80", o); end
        checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL add_flags got %b want 1001", flags); end
        inst = 8'd4; a = 8'h00; b = 8'h01;
        @(negedge CLK);
        checks++; if (o !== 8'hFF) begin errors++; $display("FAIL sub_o got %h want ff", o); end
        checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL sub_flags got %b want 1010", flags); end
        checks++; if (statupd8 !== 1'b0) begin errors++; $display("FAIL sub_stat got %b want 0", statupd8); end
        in_valid = 1'b0;
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got %b want 0", out_valid); end
    endtask

    task automatic test_cond();
        logic [7:0] ops [3];
        logic [7:0] av [3];
        logic [7:0] eo;
        logic es;
        logic [3:0] ef;
        ops = '{8'd1, 8'd2, 8'd1};
        av  = '{8'h00, 8'h80, 8'h05};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; inst = ops[i]; a = av[i]; b = 8'($urandom);
            @(negedge CLK);
            model(ops[i], av[i], b, eo, es, ef);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cond%0d_valid got %b want 1", i, out_valid); end
            checks++; if (statupd8 !== es) begin errors++; $display("FAIL cond%0d_stat got %b want %b", i, statupd8, es); end
            checks++; if (o !== 8'h00) begin errors++; $display("FAIL cond%0d_o got %h want 00", i, o); end
            checks++; if (flags !== ef) begin errors++; $display("FAIL cond%0d_flags got %b want %b", i, flags, ef); end
        end
        in_valid = 1'b0;
        @(negedge CLK);
    endtask

    // Issue one MUL, agitate in_valid while busy, check the WIDTH+1 latency and result.
    task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input string tag);
        logic [7:0] eo;
        logic es;
        logic [3:0] ef;
        model(8'd5, x, y, eo, es, ef);
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 8'd5; a = x; b = y;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy_ready c%0d got %b want 0", tag, k, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid c%0d got %b want 0", tag, k, out_valid); end
            in_valid = (k < 8) ? 1'($urandom) : 1'b0;
            inst = 8'd3; a = 8'($urandom); b = 8'($urandom);
        end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", tag, out_valid); end
        checks++; if (o !== eo) begin errors++; $display("FAIL %s_o got %h want %h", tag, o, eo); end
        checks++; if (flags !== ef) begin errors++; $display("FAIL %s_flags got %b want %b", tag, flags, ef); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain got %b want 0", tag, out_valid); end
    endtask

    task automatic test_mul();
        run_mul(8'h0D, 8'h0B, "mul");
        run_mul(8'($urandom), 8'h00, "mul_zero");
        run_mul(8'($urandom), 8'($urandom), "mul_rand");
    endtask

    task automatic test_backpressure();
        logic [7:0] x1, y1, x2, y2, eo1, eo2;
        logic es;
        logic [3:0] ef1, ef2;
        x1 = 8'($urandom); y1 = 8'($urandom);
        x2 = ~x1; y2 = 8'($urandom);
        model(8'd3, x1, y1, eo1, es, ef1);
        model(8'd3, x2, y2, eo2, es, ef2);
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 8'd3; a = x1; b = y1;
        @(negedge CLK);
        a = x2; b = y2;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", k, out_valid); end
            checks++; if (o !== eo1) begin errors++; $display("FAIL bp_o c%0d got %h want %h", k, o, eo1); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d got %b want 0", k, in_ready); end
            @(negedge CLK);
        end
        checks++; if (flags !== ef1) begin errors++; $display("FAIL bp_flags got %b want %b", flags, ef1); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        @(negedge CLK);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid got %b want 1", out_valid); end
        checks++; if (o !== eo2) begin errors++; $display("FAIL bp_reload_o got %h want %h", o, eo2); end
        checks++; if (flags !== ef2) begin errors++; $display("FAIL bp_reload_flags got %b want %b", flags, ef2); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_nop();
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 8'hFF; a = 8'($urandom) | 8'h01; b = 8'($urandom);
        @(negedge CLK);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nop_valid got %b want 1", out_valid); end
        checks++; if (o !== 8'h00) begin errors++; $display("FAIL nop_o got %h want 00", o); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL nop_flags got %b want 0000", flags); end
        checks++; if (statupd8 !== 1'b0) begin errors++; $display("FAIL nop_stat got %b want 0", statupd8); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nop_pulse got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op, x, y, eo;
        logic es;
        logic [3:0] ef;
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got %b want 1", i, out_valid); end
                checks++; if ({o, statupd8, flags} !== {eo, es, ef}) begin
                    errors++; $display("FAIL b2b%0d_result got %h/%b/%b want %h/%b/%b", i, o, statupd8, flags, eo, es, ef);
                end
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got %b want 1", i, in_ready); end
            op = rand_op(1'b0); x = 8'($urandom); y = 8'($urandom);
            in_valid = (i < 20); inst = op; a = x; b = y;
            model(op, x, y, eo, es, ef);
            @(negedge CLK);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [7:0] op, x, y, eo;
        logic es;
        logic [3:0] ef;
        int lat, stall;
        for (int n = 0; n < 40; n++) begin
            op = rand_op(1'b1); x = 8'($urandom); y = 8'($urandom);
            model(op, x, y, eo, es, ef);
            lat = (op == 8'd5) ? 9 : 1;
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            in_valid = 1'b1; inst = op; a = x; b = y;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready got %b want 1", n, in_ready); end
            @(negedge CLK);
            in_valid = 1'b0;
            for (int k = 1; k < lat; k++) @(negedge CLK);
            for (int s = 0; s <= stall; s++) begin
                checks++; if ({out_valid, o, statupd8, flags} !== {1'b1, eo, es, ef}) begin
                    errors++; $display("FAIL rnd%0d_op%0d got v%b %h/%b/%b want v1 %h/%b/%b", n, op, out_valid, o, statupd8, flags, eo, es, ef);
                end
                if (s == stall) out_ready = 1'b1;
                @(negedge CLK);
            end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_drain got %b want 0", n, out_valid); end
        end
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        in_valid = 1'b1; inst = 8'd3; a = 8'h7F; b = 8'h01;
        @(negedge CLK);
        inst = 8'd5; a = 8'hFF; b = 8'hFF;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmul_valid got %b want 0", out_valid); end
        checks++; if (o !== 8'h00) begin errors++; $display("FAIL rstmul_o got %h want 00", o); end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_ready got %b want 1", in_ready); end
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmul_late c%0d got %b want 0", k, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_cond();
        test_mul();
        test_backpressure();
        test_nop();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
